// File: rtl/esm_fetch_decode_if.sv
// esm_fetch_decode_if: instruction-memory bus between the ESM fetch/predecode
// front end and instruction memory.
//   imem_req    fetch request valid (accepted in the cycle it is asserted)
//   imem_addr   word-aligned byte address of the request
//   imem_rvalid response valid; responses return in request order
//   imem_rdata  response word
// master = fetch unit, slave = instruction memory.
interface esm_fetch_decode_if #(
  parameter int ADDR_W          = 32,
  parameter int Instr_word_size = 32
);
  logic                       imem_req;
  logic [ADDR_W-1:0]          imem_addr;
  logic                       imem_rvalid;
  logic [Instr_word_size-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_rvalid, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/esm_fetch_decode.sv
// esm_fetch_decode: upstream feeder of the ESM scheduler. Fetches RV32I words
// from instruction memory into a small FIFO, predecodes ALUSrc/RegWrite and
// delivers exactly one word (instruction or bubble) per unstalled clock.
// Halts cleanly after issuing a SYSTEM (ECALL/EBREAK) word.
// Ports:
//   clk, rst (async, active low), start (1-cycle pulse), stall (downstream hold)
//   imem        esm_fetch_decode_if.master: imem_req/imem_addr out, imem_rvalid/imem_rdata in
//   instr_o, alu_src_o, reg_write_o, instr_valid_o  registered issue outputs
//   illegal_o   sticky unknown-opcode flag, cleared on start
//   halted_o    1 in HALT
// Optional feature: define ESM_FETCH_PERF_EN to add bubble_cnt/issue_cnt outputs.
module esm_fetch_decode #(
  parameter int                Instr_word_size = 32,
  parameter int                ADDR_W          = 32,
  parameter int                DEPTH           = 4,
  parameter logic [ADDR_W-1:0] BOOT_ADDR       = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stall,
  esm_fetch_decode_if.master         imem,
  output logic [Instr_word_size-1:0] instr_o,
  output logic                       alu_src_o,
  output logic                       reg_write_o,
  output logic                       instr_valid_o,
  output logic                       illegal_o,
  output logic                       halted_o
`ifdef ESM_FETCH_PERF_EN
  ,
  output logic [31:0]                bubble_cnt,
  output logic [31:0]                issue_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [Instr_word_size-1:0] NOP = Instr_word_size'(32'h0000_0013);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          pc_q, pc_d;
  logic [Instr_word_size-1:0] fifo_q [DEPTH];
  logic [Instr_word_size-1:0] fifo_d [DEPTH];
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d, outst_q, outst_d;
  logic [Instr_word_size-1:0] instr_q, instr_d;
  logic                       alu_q, alu_d, rw_q, rw_d, valid_q, valid_d;
  logic                       illegal_q, illegal_d;
`ifdef ESM_FETCH_PERF_EN
  logic [31:0]                bubble_q, bubble_d, issue_q, issue_d;
`endif

  logic                       req, push, pop, flush, restart;
  logic [CW:0]                occ;
  logic [Instr_word_size-1:0] head;
  logic [3:0]                 pre;

  // Returns {alu_src, reg_write, illegal, system}.
  function automatic logic [3:0] predecode(input logic [Instr_word_size-1:0] w);
    logic alu, rw, ill, sys;
    alu = 1'b0;
    rw  = 1'b0;
    ill = 1'b0;
    sys = 1'b0;
    case (w[6:0])
      7'b0110011: begin alu = 1'b0; rw = 1'b1; end
      7'b0010011, 7'b0000011,
      7'b0110111, 7'b0010111,
      7'b1101111, 7'b1100111: begin alu = 1'b1; rw = 1'b1; end
      7'b0100011: begin alu = 1'b1; rw = 1'b0; end
      7'b1100011: begin alu = 1'b0; rw = 1'b0; end
      7'b1110011: sys = 1'b1;
      default:    ill = 1'b1;
    endcase
    if (w[11:7] == 5'd0) rw = 1'b0;
    return {alu, rw, ill, sys};
  endfunction

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    outst_d   = outst_q;
    instr_d   = instr_q;
    alu_d     = alu_q;
    rw_d      = rw_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
`ifdef ESM_FETCH_PERF_EN
    bubble_d  = bubble_q;
    issue_d   = issue_q;
`endif

    // Credit rule: FIFO occupancy plus in-flight requests never exceeds DEPTH,
    // so a returning response always has a free slot.
    occ     = (CW+1)'(count_q) + (CW+1)'(outst_q);
    req     = (state_q == S_RUN) && (occ < (CW+1)'(DEPTH));
    head    = fifo_q[rd_ptr_q];
    pre     = predecode(head);
    pop     = !stall && (state_q == S_RUN) && (count_q != '0);
    flush   = pop && pre[0];
    // Responses outside RUN (i.e. in DRAIN) only return credit.
    push    = imem.imem_rvalid && (state_q == S_RUN) && !flush;
    restart = start && ((state_q == S_IDLE) || (state_q == S_HALT));

    case ({req, imem.imem_rvalid})
      2'b10:   outst_d = outst_q + CNT_ONE;
      2'b01:   outst_d = (outst_q != '0) ? outst_q - CNT_ONE : outst_q;
      default: outst_d = outst_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = imem.imem_rdata;
        wr_ptr_d         = wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
    end

    if (!stall) begin
      if (pop) begin
        instr_d = head;
        alu_d   = pre[3];
        rw_d    = pre[2];
        valid_d = 1'b1;
        if (pre[1]) illegal_d = 1'b1;
      end else begin
        instr_d = NOP;
        alu_d   = 1'b1;
        rw_d    = 1'b0;
        valid_d = 1'b0;
      end
    end

`ifdef ESM_FETCH_PERF_EN
    if (pop && issue_q != '1) issue_d = issue_q + 32'd1;
    if (!stall && (state_q == S_RUN) && !pop && bubble_q != '1) bubble_d = bubble_q + 32'd1;
    if (restart) begin
      issue_d  = '0;
      bubble_d = '0;
    end
`endif

    case (state_q)
      S_IDLE, S_HALT: begin
        if (restart) begin
          state_d   = S_RUN;
          pc_d      = BOOT_ADDR;
          illegal_d = 1'b0;
        end
      end
      S_RUN: begin
        if (req)   pc_d    = pc_q + ADDR_W'(4);
        if (flush) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (outst_q == '0) state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= BOOT_ADDR;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      instr_q   <= NOP;
      alu_q     <= 1'b1;
      rw_q      <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ESM_FETCH_PERF_EN
      bubble_q  <= '0;
      issue_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      instr_q   <= instr_d;
      alu_q     <= alu_d;
      rw_q      <= rw_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
`ifdef ESM_FETCH_PERF_EN
      bubble_q  <= bubble_d;
      issue_q   <= issue_d;
`endif
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign instr_o        = instr_q;
  assign alu_src_o      = alu_q;
  assign reg_write_o    = rw_q;
  assign instr_valid_o  = valid_q;
  assign illegal_o      = illegal_q;
  assign halted_o       = (state_q == S_HALT);
`ifdef ESM_FETCH_PERF_EN
  assign bubble_cnt     = bubble_q;
  assign issue_cnt      = issue_q;
`endif

endmodule

// File: tb/tb_esm_fetch_decode.sv
`timescale 1ns/1ps
module tb_esm_fetch_decode;
  localparam int DEPTH = 4;
  localparam logic [31:0] ADDI1  = 32'h0050_0093;
  localparam logic [31:0] ECALL  = 32'h0000_0073;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  always #5 clk = ~clk;

  esm_fetch_decode_if #(.ADDR_W(32), .Instr_word_size(32)) imem ();

  logic [31:0] instr_o;
  logic        alu_src_o, reg_write_o, instr_valid_o, illegal_o, halted_o;
`ifdef ESM_FETCH_PERF_EN
  logic [31:0] bubble_cnt, issue_cnt;
`endif

  esm_fetch_decode #(.Instr_word_size(32), .ADDR_W(32), .DEPTH(DEPTH), .BOOT_ADDR(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stall         (stall),
    .imem          (imem),
    .instr_o       (instr_o),
    .alu_src_o     (alu_src_o),
    .reg_write_o   (reg_write_o),
    .instr_valid_o (instr_valid_o),
    .illegal_o     (illegal_o),
    .halted_o      (halted_o)
`ifdef ESM_FETCH_PERF_EN
    ,
    .bubble_cnt    (bubble_cnt),
    .issue_cnt     (issue_cnt)
`endif
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Spec-level predecode: {alu_src, reg_write}.
  function automatic logic [1:0] spec_ar(input logic [31:0] w);
    logic [1:0] r;
    case (w[6:0])
      7'h33:                                 r = 2'b01;
      7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67: r = 2'b11;
      7'h23:                                 r = 2'b10;
      default:                               r = 2'b00;
    endcase
    if (w[11:7] == 5'd0) r[0] = 1'b0;
    return r;
  endfunction

  function automatic bit spec_known(input logic [31:0] w);
    case (w[6:0])
      7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction memory and the behavioural model.
  logic [31:0] mem [64];
  int unsigned lat = 1;

  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;
  pend_t       pend [$];
  logic [31:0] expq [$];
  int unsigned ncyc = 0;
  bit          started = 0, drop = 0, ill_exp = 0, restart_pend = 0, prev_stall = 0;
  int unsigned prev_qsize = 0;
  logic [34:0] prev_out = '0;
  logic [31:0] exp_addr = '0;
  logic [31:0] last_valid = '0;
  int unsigned valid_cnt = 0;

  always @(negedge clk) begin
    logic [31:0] w;
    bit          exp_valid;
    ncyc++;
    if (!rst) begin
      expq.delete();
      pend.delete();
      started = 0; drop = 0; ill_exp = 0; restart_pend = 0; prev_stall = 0; prev_qsize = 0;
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = '0;
      chk("reset_outputs", 64'({instr_o, alu_src_o, reg_write_o, instr_valid_o, illegal_o, halted_o, imem.imem_req}),
          64'({32'h13, 1'b1, 5'b0}));
    end else begin
      if (restart_pend) begin
        started = 1; drop = 0; ill_exp = 0; expq.delete(); exp_addr = '0; valid_cnt = 0;
        restart_pend = 0;
      end
      // Issue observed after the last rising edge.
      if (prev_stall) begin
        chk("stall_hold", 64'({instr_o, alu_src_o, reg_write_o, instr_valid_o}), 64'(prev_out));
      end else begin
        exp_valid = started && !drop && (prev_qsize > 0);
        chk("issue_valid", 64'(instr_valid_o), 64'(exp_valid));
        if (instr_valid_o && expq.size() > 0) begin
          w = expq.pop_front();
          chk("issue_word", 64'(instr_o), 64'(w));
          chk("issue_predecode", 64'({alu_src_o, reg_write_o}), 64'(spec_ar(w)));
          valid_cnt++;
          last_valid = w;
          if (w[6:0] == 7'h73) begin
            drop = 1;
            expq.delete();
          end else if (!spec_known(w)) begin
            ill_exp = 1;
          end
        end else if (!instr_valid_o) begin
          chk("bubble", 64'({instr_o, alu_src_o, reg_write_o}), 64'({32'h13, 1'b1, 1'b0}));
        end
      end
      chk("illegal_flag", 64'(illegal_o), 64'(ill_exp));
      // Response sampled at the last rising edge enters the FIFO unless dropped.
      if (imem.imem_rvalid && started && !drop) expq.push_back(imem.imem_rdata);
      if (halted_o) chk("halt_only_when_drained", 64'(drop && pend.size() == 0), 64'd1);
      // Memory: drive the next in-order response once its latency has elapsed.
      if (pend.size() > 0 && pend[0].due <= ncyc) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = mem[pend[0].addr[7:2]];
        void'(pend.pop_front());
      end else begin
        imem.imem_rvalid = 1'b0;
      end
      if (imem.imem_req) begin
        chk("req_addr", 64'(imem.imem_addr), 64'(exp_addr));
        chk("req_in_run", 64'(started && !drop), 64'd1);
        exp_addr = exp_addr + 32'd4;
        pend.push_back('{addr: imem.imem_addr, due: ncyc + lat});
        chk("credit", 64'(pend.size() <= DEPTH), 64'd1);
      end
      prev_stall = stall;
      prev_out   = {instr_o, alu_src_o, reg_write_o, instr_valid_o};
      prev_qsize = expq.size();
      if (start) restart_pend = 1;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int unsigned maxc);
    int unsigned c = 0;
    while (!halted_o && c < maxc) begin
      tick(1);
      c++;
    end
    chk("halt_reached", 64'(halted_o), 64'd1);
`ifdef ESM_FETCH_PERF_EN
    chk("issue_cnt", 64'(issue_cnt), 64'(valid_cnt));
`endif
  endtask

  task automatic fill_addi(input int unsigned n, input int unsigned ecall_at);
    for (int i = 0; i < 64; i++)
      mem[i] = (32'(i + 1) << 20) | (32'((i % 31) + 1) << 7) | 32'h13;
    for (int i = 0; i < 64; i++) if (i < int'(n)) mem[i] = ADDI1;
    mem[ecall_at] = ECALL;
  endtask

  logic [31:0] sweep_w  [7] = '{32'h0020_81B3, 32'h0020_A023, 32'h0020_8063, 32'h0010_0013,
                                32'h0000_007F, 32'h0000_12B7, ECALL};
  logic [1:0]  sweep_ar [7] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00};

  initial begin
    int unsigned k;
    int unsigned bub;
    fill_addi(8, 8);
    tick(2);
    chk("reset_state", 64'({instr_o, alu_src_o, reg_write_o, instr_valid_o, illegal_o, halted_o, imem.imem_req}),
        64'({32'h13, 1'b1, 5'b0}));
    rst = 1'b1;
    tick(2);

    // 1: basic fetch, 1-cycle memory, first issue three cycles after start.
    lat = 1;
    do_start();
    chk("t1_req0", 64'({imem.imem_req, imem.imem_addr}), 64'({1'b1, 32'h0}));
    tick(1);
    chk("t1_addr4", 64'(imem.imem_addr), 64'h4);
    tick(1);
    chk("t1_addr8_novalid", 64'({imem.imem_addr, instr_valid_o}), 64'({32'h8, 1'b0}));
    tick(1);
    chk("t1_first_issue", 64'({instr_o, alu_src_o, reg_write_o, instr_valid_o}), 64'({ADDI1, 3'b111}));
    wait_halt(200);
    chk("t1_issued", 64'(valid_cnt), 64'd9);

    // 2: predecode sweep including an unknown opcode.
    lat = 2;
    fill_addi(0, 6);
    for (int i = 0; i < 7; i++) mem[i] = sweep_w[i];
    do_start();
    k = 0;
    for (int c = 0; c < 80 && !halted_o; c++) begin
      if (instr_valid_o && k < 7) begin
        chk("t2_instr", 64'(instr_o), 64'(sweep_w[k]));
        chk("t2_predecode", 64'({alu_src_o, reg_write_o}), 64'(sweep_ar[k]));
        k++;
      end
      tick(1);
    end
    chk("t2_count", 64'(k), 64'd7);
    wait_halt(50);
    chk("t2_illegal_sticky", 64'(illegal_o), 64'd1);

    // 3: 5-cycle memory latency exceeds DEPTH, so bubbles appear.
    lat = 5;
    fill_addi(0, 16);
    do_start();
    chk("t3_illegal_cleared", 64'(illegal_o), 64'd0);
    bub = 0;
    for (int c = 0; c < 300 && !halted_o; c++) begin
      if (!instr_valid_o && c > 8 && valid_cnt < 17) bub++;
      tick(1);
    end
    chk("t3_bubbles_seen", 64'(bub > 0), 64'd1);
    wait_halt(50);
    chk("t3_issued", 64'(valid_cnt), 64'd17);

    // 4: six-cycle stall with the FIFO filling up.
    lat = 1;
    fill_addi(0, 24);
    do_start();
    tick(8);
    stall = 1'b1;
    tick(3);
    chk("t4_req_off_full", 64'(imem.imem_req), 64'd0);
    tick(3);
    stall = 1'b0;
    wait_halt(200);
    chk("t4_issued", 64'(valid_cnt), 64'd25);

    // 5: ECALL at address 8, then restart from BOOT_ADDR.
    lat = 3;
    fill_addi(0, 2);
    do_start();
    wait_halt(200);
    chk("t5_issued", 64'(valid_cnt), 64'd3);
    chk("t5_last_is_ecall", 64'(last_valid), 64'(ECALL));
    do_start();
    chk("t5_restart", 64'({halted_o, imem.imem_req, imem.imem_addr}), 64'({1'b0, 1'b1, 32'h0}));
    wait_halt(200);
    chk("t5_reissued", 64'(valid_cnt), 64'd3);

    // 6: reset mid-run with requests outstanding.
    lat = 4;
    fill_addi(0, 40);
    do_start();
    tick(2);
    rst = 1'b0;
    #1;
    chk("t6_async_reset", 64'({instr_o, alu_src_o, reg_write_o, instr_valid_o, illegal_o, halted_o, imem.imem_req}),
        64'({32'h13, 1'b1, 5'b0}));
`ifdef ESM_FETCH_PERF_EN
    chk("t6_counters_zero", 64'({bubble_cnt, issue_cnt}), 64'd0);
`endif
    tick(2);
    rst = 1'b1;
    tick(3);
    chk("t6_idle_after_reset", 64'({instr_valid_o, halted_o, imem.imem_req}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
